// File: rtl/spram_pkg.sv
// Shared types and default sizes for the single-port RAM arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spram_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 6;
    localparam int LOCK_MAX_DEF = 16;

    // Requester identifier: one bit selects between the two masters.
    typedef logic req_id_t;
    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    // Tag travelling alongside a read so the returning data finds its owner.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/spram_arbiter_rr_arb2.sv
// Two-way round-robin grant with an ownership lock and an idle-owner timeout.
// Latency: grants are combinational from valid and registered arbiter state.
// Backpressure: a non-granted requester simply sees no grant and keeps holding.
module rr_arb2
    import spram_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic lock0,
    input  logic lock1,
    output logic grant0,
    output logic grant1,
    output logic lock_err
);

    localparam logic [7:0] IDLE_LAST = 8'(LOCK_MAX - 1);

    req_id_t    ptr;
    req_id_t    owner;
    logic       owner_vld;
    logic [7:0] idle_cnt;

    logic       acc0;
    logic       acc1;
    logic       acc_any;
    req_id_t    acc_id;
    logic       acc_lock;
    logic       owner_idle;
    logic       timeout;

    // Grant selection: a lock owner excludes the other side, otherwise round robin.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (owner_vld) begin
            grant0 = (owner == REQ0);
            grant1 = (owner == REQ1);
        end else if (valid0 && valid1) begin
            grant0 = (ptr == REQ0);
            grant1 = (ptr == REQ1);
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
    end

    // Acceptance and timeout detection; only the owner can be accepted while locked.
    always_comb begin
        acc0       = valid0 & grant0;
        acc1       = valid1 & grant1;
        acc_any    = acc0 | acc1;
        acc_id     = acc1 ? REQ1 : REQ0;
        acc_lock   = acc1 ? lock1 : lock0;
        owner_idle = owner_vld & ~acc_any;
        timeout    = owner_idle & (idle_cnt == IDLE_LAST);
        lock_err   = timeout;
    end

    // Pointer, owner and idle counter; an acceptance always beats a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= REQ0;
            owner     <= REQ0;
            owner_vld <= 1'b0;
            idle_cnt  <= 8'd0;
        end else if (acc_any) begin
            if (!owner_vld) begin
                ptr <= other_req(acc_id);
            end
            owner     <= acc_id;
            owner_vld <= acc_lock;
            idle_cnt  <= 8'd0;
        end else if (timeout) begin
            ptr       <= other_req(owner);
            owner_vld <= 1'b0;
            idle_cnt  <= 8'd0;
        end else if (owner_idle) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port registered-read RAM between two requesters.
// Latency: RAM controls registered at acceptance; read data returns 3 cycles after the ready cycle.
// Backpressure: combinational ready per requester, one acceptance per cycle, no switch bubble.
module spram_arbiter
    import spram_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rq0_valid,
    input  logic              rq0_we,
    input  logic              rq0_lock,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ready,
    output logic              rq0_rvalid,
    output logic [DATA_W-1:0] rq0_rdata,
    input  logic              rq1_valid,
    input  logic              rq1_we,
    input  logic              rq1_lock,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ready,
    output logic              rq1_rvalid,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic              lock_err
);

    logic              grant0;
    logic              grant1;
    logic              acc_any;
    req_id_t           sel_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    rd_tag_t           tag_s1;
    rd_tag_t           tag_s2;

    rr_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid0   (rq0_valid),
        .valid1   (rq1_valid),
        .lock0    (rq0_lock),
        .lock1    (rq1_lock),
        .grant0   (grant0),
        .grant1   (grant1),
        .lock_err (lock_err)
    );

    // Ready and the request mux for whichever side is accepted this cycle.
    always_comb begin
        rq0_ready = rq0_valid & grant0;
        rq1_ready = rq1_valid & grant1;
        acc_any   = rq0_ready | rq1_ready;
        sel_id    = rq1_ready ? REQ1 : REQ0;
        sel_we    = rq1_ready ? rq1_we : rq0_we;
        sel_addr  = rq1_ready ? rq1_addr : rq0_addr;
        sel_wdata = rq1_ready ? rq1_wdata : rq0_wdata;
    end

    // RAM control registers: address/data hold when idle, write strobe lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else if (acc_any) begin
            ram_we   <= sel_we;
            ram_addr <= sel_addr;
            ram_data <= sel_wdata;
        end else begin
            ram_we <= 1'b0;
        end
    end

    // Read tags: stage 1 aligns with the RAM sampling edge, stage 2 with q being valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_s1 <= '0;
            tag_s2 <= '0;
        end else begin
            tag_s1 <= '{valid: acc_any & ~sel_we, id: sel_id};
            tag_s2 <= tag_s1;
        end
    end

    // Return path: capture q into the tagged requester's data register and pulse rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq0_rvalid <= 1'b0;
            rq1_rvalid <= 1'b0;
            rq0_rdata  <= '0;
            rq1_rdata  <= '0;
        end else begin
            rq0_rvalid <= tag_s2.valid & (tag_s2.id == REQ0);
            rq1_rvalid <= tag_s2.valid & (tag_s2.id == REQ1);
            if (tag_s2.valid && tag_s2.id == REQ0) begin
                rq0_rdata <= ram_q;
            end
            if (tag_s2.valid && tag_s2.id == REQ1) begin
                rq1_rdata <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model expects ram controls one cycle and rvalid three cycles after the ready cycle.
// Backpressure: stimulus holds each request stable until the DUT shows ready.
module tb_spram_arbiter;
    import spram_pkg::*;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int LM = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          rq0_valid, rq0_we, rq0_lock, rq0_ready, rq0_rvalid;
    logic [AW-1:0] rq0_addr;
    logic [DW-1:0] rq0_wdata, rq0_rdata;
    logic          rq1_valid, rq1_we, rq1_lock, rq1_ready, rq1_rvalid;
    logic [AW-1:0] rq1_addr;
    logic [DW-1:0] rq1_wdata, rq1_rdata;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_q = '0;
    logic          lock_err;

    spram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_lock(rq0_lock), .rq0_addr(rq0_addr),
        .rq0_wdata(rq0_wdata), .rq0_ready(rq0_ready), .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
        .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_lock(rq1_lock), .rq1_addr(rq1_addr),
        .rq1_wdata(rq1_wdata), .rq1_ready(rq1_ready), .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
        .lock_err(lock_err)
    );

    // Single-port RAM with registered read, cleared on the first clock.
    logic [DW-1:0] mem [0:63];
    bit mem_clear = 1'b1;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem_clear <= 1'b0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_data;
            ram_q <= mem[ram_addr];
        end
    end

    typedef struct {
        int          due;
        int          id;
        logic [7:0]  data;
    } ret_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model state
    int            m_owner, m_ptr, m_idle;
    bit            m_ram_we;
    logic [AW-1:0] m_ram_addr;
    logic [DW-1:0] m_ram_data;
    logic [DW-1:0] m_rdata [2];
    logic [DW-1:0] shadow [64];
    ret_t          pend[$];
    ret_t          dlog[$];

    // Observations of the DUT in the most recent checked cycle
    int obs_g;
    bit obs_lerr, obs_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_idle = 0;
        m_ram_we = 0; m_ram_addr = '0; m_ram_data = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        pend.delete();
    endtask

    task automatic model_cycle();
        int g;
        bit v[2];
        bit idle, exp_lerr;
        bit exp_rv[2];
        bit we_g, lk_g;
        logic [AW-1:0] a_g;
        logic [DW-1:0] d_g;
        ret_t r;
        v[0] = rq0_valid; v[1] = rq1_valid;
        g = -1;
        if (m_owner >= 0) begin
            if (v[m_owner]) g = m_owner;
        end else if (v[0] && v[1]) g = m_ptr;
        else if (v[0]) g = 0;
        else if (v[1]) g = 1;
        idle = (m_owner >= 0) && (g < 0);
        exp_lerr = idle && (m_idle + 1 == LM);
        exp_rv[0] = 0; exp_rv[1] = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            exp_rv[r.id] = 1;
            m_rdata[r.id] = r.data;
        end
        chk("rq0_ready", 32'(rq0_ready), 32'(g == 0));
        chk("rq1_ready", 32'(rq1_ready), 32'(g == 1));
        chk("lock_err", 32'(lock_err), 32'(exp_lerr));
        chk("ram_we", 32'(ram_we), 32'(m_ram_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_ram_addr));
        chk("ram_data", 32'(ram_data), 32'(m_ram_data));
        chk("rq0_rvalid", 32'(rq0_rvalid), 32'(exp_rv[0]));
        chk("rq1_rvalid", 32'(rq1_rvalid), 32'(exp_rv[1]));
        chk("rq0_rdata", 32'(rq0_rdata), 32'(m_rdata[0]));
        chk("rq1_rdata", 32'(rq1_rdata), 32'(m_rdata[1]));
        obs_g = rq0_ready ? 0 : (rq1_ready ? 1 : -1);
        obs_lerr = lock_err;
        obs_we = ram_we;
        if (rq0_rvalid) begin r.due = cyc; r.id = 0; r.data = rq0_rdata; dlog.push_back(r); end
        if (rq1_rvalid) begin r.due = cyc; r.id = 1; r.data = rq1_rdata; dlog.push_back(r); end
        if (g >= 0) begin
            we_g = (g == 1) ? rq1_we : rq0_we;
            lk_g = (g == 1) ? rq1_lock : rq0_lock;
            a_g  = (g == 1) ? rq1_addr : rq0_addr;
            d_g  = (g == 1) ? rq1_wdata : rq0_wdata;
            m_ram_we = we_g; m_ram_addr = a_g; m_ram_data = d_g;
            if (we_g) shadow[a_g] = d_g;
            else begin
                r.due = cyc + 3; r.id = g; r.data = shadow[a_g];
                pend.push_back(r);
            end
            if (m_owner < 0) m_ptr = 1 - g;
            m_owner = lk_g ? g : -1;
            m_idle = 0;
        end else begin
            m_ram_we = 0;
            if (idle) begin
                if (m_idle + 1 == LM) begin
                    m_ptr = 1 - m_owner;
                    m_owner = -1;
                    m_idle = 0;
                end else m_idle++;
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int n, input bit v, input bit we, input bit lk, input int a, input int d);
        if (n == 0) begin
            rq0_valid = v; rq0_we = we; rq0_lock = lk; rq0_addr = AW'(a); rq0_wdata = DW'(d);
        end else begin
            rq1_valid = v; rq1_we = we; rq1_lock = lk; rq1_addr = AW'(a); rq1_wdata = DW'(d);
        end
    endtask

    task automatic acc(input int n, input bit we, input bit lk, input int a, input int d, output int ac);
        set_rq(n, 1, we, lk, a, d);
        ac = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (obs_g == n) begin
                ac = cyc - 1;
                break;
            end
        end
        if (ac < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_data", 32'(ram_data), 32'd0);
        chk("rst_rq0_rvalid", 32'(rq0_rvalid), 32'd0);
        chk("rst_rq1_rvalid", 32'(rq1_rvalid), 32'd0);
        chk("rst_rq0_rdata", 32'(rq0_rdata), 32'd0);
        chk("rst_rq1_rdata", 32'(rq1_rdata), 32'd0);
        chk("rst_lock_err", 32'(lock_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_req(input int n, input int dens);
        bit hold;
        hold = (n == 0) ? (rq0_valid && obs_g != 0) : (rq1_valid && obs_g != 1);
        if (!hold) begin
            set_rq(n, $urandom_range(0, dens - 1) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 7), $urandom_range(0, 255));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac[3];
        int tmp;
        int gl[8];
        int n0;
        for (int i = 0; i < 64; i++) shadow[i] = '0;
        set_rq(0, 0, 0, 0, 0, 0);
        set_rq(1, 0, 0, 0, 0, 0);
        obs_g = -1;
        model_reset();
        apply_reset();

        // Writes then reads from rq0
        dlog.delete();
        acc(0, 1, 0, 0, 8'h01, tmp);
        acc(0, 1, 0, 1, 8'h02, tmp);
        acc(0, 1, 0, 2, 8'h03, tmp);
        for (int i = 0; i < 3; i++) acc(0, 0, 0, i, 0, ac[i]);
        set_rq(0, 0, 0, 0, 0, 0);
        repeat (5) step();
        chk("t1_nret", dlog.size(), 3);
        for (int i = 0; i < 3 && i < dlog.size(); i++) begin
            chk("t1_id", dlog[i].id, 0);
            chk("t1_data", 32'(dlog[i].data), 32'(i + 1));
            chk("t1_when", dlog[i].due, ac[i] + 3);
        end

        // Contention: alternating grants after reset, starting with rq0
        acc(0, 1, 0, 1, 8'h11, tmp);
        set_rq(0, 0, 0, 0, 0, 0);
        acc(1, 1, 0, 2, 8'h22, tmp);
        set_rq(1, 0, 0, 0, 0, 0);
        step();
        apply_reset();
        dlog.delete();
        set_rq(0, 1, 0, 0, 1, 0);
        set_rq(1, 1, 0, 0, 2, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            gl[k] = obs_g;
        end
        set_rq(0, 0, 0, 0, 0, 0);
        set_rq(1, 0, 0, 0, 0, 0);
        repeat (4) step();
        for (int k = 0; k < 8; k++) chk("t2_grant", gl[k], k % 2);
        chk("t2_nret", dlog.size(), 8);
        for (int k = 0; k < 8 && k < dlog.size(); k++) begin
            chk("t2_ret_id", dlog[k].id, k % 2);
            chk("t2_ret_data", 32'(dlog[k].data), (k % 2) ? 32'h22 : 32'h11);
        end

        // Lock: rq1 read-modify-write of address 1 while rq0 waits
        apply_reset();
        dlog.delete();
        set_rq(1, 1, 0, 1, 1, 0);
        step();
        chk("t3_lock_acc", obs_g, 1);
        set_rq(1, 0, 0, 0, 0, 0);
        set_rq(0, 1, 0, 0, 1, 0);
        step();
        chk("t3_wait_a", obs_g, -1);
        step();
        chk("t3_wait_b", obs_g, -1);
        set_rq(1, 1, 1, 0, 1, 8'h04);
        step();
        chk("t3_owner_wr", obs_g, 1);
        set_rq(1, 0, 0, 0, 0, 0);
        step();
        chk("t3_rq0_after", obs_g, 0);
        set_rq(0, 0, 0, 0, 0, 0);
        repeat (4) step();
        chk("t3_nret", dlog.size(), 2);
        if (dlog.size() == 2) begin
            chk("t3_rmw_old", 32'(dlog[0].data), 32'h11);
            chk("t3_rq0_id", dlog[1].id, 0);
            chk("t3_rq0_data", 32'(dlog[1].data), 32'h04);
        end

        // Timeout: rq0 locks then goes quiet; rq1 waits
        apply_reset();
        dlog.delete();
        set_rq(0, 1, 1, 1, 5, 8'h55);
        step();
        chk("t4_lock_acc", obs_g, 0);
        set_rq(0, 0, 0, 0, 0, 0);
        set_rq(1, 1, 0, 0, 5, 0);
        for (int k = 1; k <= 17; k++) begin
            step();
            chk("t4_lock_err", 32'(obs_lerr), 32'(k == 16));
            chk("t4_grant", obs_g, (k == 17) ? 1 : -1);
        end
        set_rq(1, 0, 0, 0, 0, 0);
        repeat (4) step();
        chk("t4_nret", dlog.size(), 1);
        if (dlog.size() == 1) chk("t4_data", 32'(dlog[0].data), 32'h55);

        // Reset with a read in flight
        dlog.delete();
        acc(0, 0, 0, 3, 0, tmp);
        set_rq(0, 0, 0, 0, 0, 0);
        step();
        apply_reset();
        repeat (6) step();
        chk("t5_no_rvalid", dlog.size(), 0);
        set_rq(0, 1, 0, 0, 4, 0);
        set_rq(1, 1, 0, 0, 5, 0);
        step();
        chk("t5_first_grant", obs_g, 0);
        set_rq(0, 0, 0, 0, 0, 0);
        set_rq(1, 0, 0, 0, 0, 0);
        repeat (4) step();

        // Write isolation
        dlog.delete();
        acc(0, 1, 0, 9, 8'h99, tmp);
        set_rq(0, 0, 0, 0, 0, 0);
        step();
        chk("t6_we_on", 32'(obs_we), 32'd1);
        step();
        chk("t6_we_off", 32'(obs_we), 32'd0);
        repeat (3) step();
        chk("t6_no_rvalid", dlog.size(), 0);

        // Randomized traffic with varying request density
        n0 = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) n0 = (n0 == 2) ? 8 : 2;
            rand_req(0, n0);
            rand_req(1, n0);
            step();
        end
        set_rq(0, 0, 0, 0, 0, 0);
        set_rq(1, 0, 0, 0, 0, 0);
        repeat (6) step();
        chk("rand_drain", pend.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
